call_stack_ctrl: RTL and testbench
==================================

# call_stack_ctrl

Subroutine call/return controller for the 8-bit processor. It is the initiator side of the `stek` LIFO's push/pop command interface. On CALL it pushes the return address (pc+1) and redirects the PC to the call target. On RET it pops the saved address and redirects the PC to it. The controller tracks stack occupancy itself, flags overflow and underflow, and sits between the control unit and the `stek` instance.

## Interface
- WIDTH, 8, address/data width; must equal the stack's WIDTH
- DEPTH, 8, stack capacity in entries; must equal the stack array size (2**3)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- call  in  1  request: push pc+1, jump to target; sampled only in IDLE
- ret  in  1  request: pop, jump to popped value; sampled only in IDLE
- clr_err  in  1  synchronous clear of the sticky error flags
- pc  in  WIDTH  current PC; sampled with call
- target  in  WIDTH  call destination; sampled with call
- stk_q  in  WIDTH  stack `y` output
- stk_con  out  2  stack command: 2'b01 push, 2'b10 pop, 2'b00 idle
- stk_data  out  WIDTH  stack `a` input (the return address)
- pc_load  out  1  one-cycle strobe: the PC loads pc_next
- pc_next  out  WIDTH  new PC value; valid while pc_load is high
- busy  out  1  high in every state except IDLE
- depth  out  $clog2(DEPTH+1)  current number of stack entries
- overflow  out  1  sticky; a call was attempted with depth==DEPTH
- underflow  out  1  sticky; a ret was attempted with depth==0
- illegal  out  1  sticky; call and ret were high together in IDLE

## Operation
- FSM states: IDLE, PUSH, POP, RWAIT, LOAD. All outputs are registered or decoded from the registered state only, with no input-to-output combinational paths.
- IDLE, call=1, ret=0, depth<DEPTH:
  - capture stk_data = pc+1, computed modulo 2^WIDTH (so 8'hFF becomes 8'h00);
  - capture pc_next = target;
  - go to PUSH.
- PUSH: stk_con=01 for exactly one cycle. depth increments at the end of the cycle. Go to LOAD.
- IDLE, ret=1, call=0, depth>0: go to POP.
- POP: stk_con=10 for one cycle. The stack updates `y` on the edge that ends POP. depth decrements at that edge. Go to RWAIT.
- RWAIT: capture pc_next = stk_q at the end of the cycle. Go to LOAD.
- LOAD: pc_load=1 for one cycle, then go to IDLE.
- Call with depth==DEPTH: set overflow. No push, no pc_load, stay in IDLE.
- Ret with depth==0: set underflow. No pop, no pc_load, stay in IDLE.
- call and ret both high in IDLE: set illegal. No action. This check takes priority over the overflow/underflow checks.
- call/ret while busy: ignored, not queued. The requester holds off until busy is low.
- clr_err=1 clears overflow, underflow and illegal on the next edge. If a new error is detected in that same cycle, setting the flag wins over clearing it.
- depth saturates within 0..DEPTH by construction; it never wraps.

## Timing
- Reset values: state IDLE; stk_con=00; stk_data=0; pc_load=0; pc_next=0; busy=0; depth=0; all error flags 0.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously and stk_con drops to 00 at once. Any in-flight push/pop is abandoned with no pc_load. The system reset must also reinitialise the stack pointer, because the controller treats the stack as empty after reset.
- CALL accepted at edge E0:
  - PUSH (stk_con=01) in cycle E0..E1;
  - pc_load in cycle E1..E2.
  - Latency from request to pc_load is 2 cycles; busy is high for 2 cycles.
- RET accepted at edge E0:
  - POP in E0..E1;
  - RWAIT in E1..E2;
  - pc_load in E2..E3.
  - Latency is 3 cycles; busy is high for 3 cycles.
- A back-to-back request may be sampled in the cycle after LOAD, once busy=0.
- stk_data is stable from the PUSH cycle through the next accepted call.

## Test plan
- Reset, then call with pc=8'h10, target=8'h40 -> stk_con=01 with stk_data=8'h11 in cycle 1; pc_load=1 with pc_next=8'h40 in cycle 2; depth=1.
- After the previous call, ret -> stk_con=10 in cycle 1; pc_load=1 with pc_next=8'h11 in cycle 3; depth=0.
- Nested calls with pc=8'h00..8'h07, then 8 rets -> pc_next returns 8'h08, 8'h07 … 8'h01 in LIFO order. A 9th call at depth=8 sets overflow and gives no pc_load.
- Ret at depth=0 -> underflow=1, stk_con stays 00. Then clr_err -> underflow=0 after one edge.
- call=ret=1 in IDLE -> illegal=1, no stack command. Call with pc=8'hFF -> stk_data=8'h00.
- Reset asserted during RWAIT -> stk_con=00, busy=0, depth=0 immediately, and no pc_load is ever issued.

Source files
------------

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: subroutine call/return controller driving the push/pop
// command port of the stek LIFO. It tracks stack occupancy, redirects the
// PC on CALL/RET, and keeps sticky overflow/underflow/illegal flags.
module call_stack_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           pc,
  input  logic [WIDTH-1:0]           target,
  input  logic [WIDTH-1:0]           stk_q,
  output logic [1:0]                 stk_con,
  output logic [WIDTH-1:0]           stk_data,
  output logic                       pc_load,
  output logic [WIDTH-1:0]           pc_next,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       illegal
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0]    DEPTH_ONE = DW'(1);
  localparam logic [WIDTH-1:0] PC_ONE    = WIDTH'(1);

  localparam logic [1:0] CON_IDLE = 2'b00;
  localparam logic [1:0] CON_PUSH = 2'b01;
  localparam logic [1:0] CON_POP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    RWAIT,
    LOAD
  } state_t;

  state_t state;

  // Controller FSM: sequences push/pop, tracks depth, registers every output.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stk_con   <= CON_IDLE;
      stk_data  <= '0;
      pc_load   <= 1'b0;
      pc_next   <= '0;
      busy      <= 1'b0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      // NOTE: the clear is written first so a later set in the same cycle
      // overrides it; with non-blocking assignments the last write wins.
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
        illegal   <= 1'b0;
      end

      stk_con <= CON_IDLE;
      pc_load <= 1'b0;

      case (state)
        IDLE: begin
          if (call && ret) begin
            illegal <= 1'b1;
          end else if (call) begin
            if (depth == DEPTH_MAX) begin
              overflow <= 1'b1;
            end else begin
              stk_data <= pc + PC_ONE;
              pc_next  <= target;
              stk_con  <= CON_PUSH;
              busy     <= 1'b1;
              state    <= PUSH;
            end
          end else if (ret) begin
            if (depth == '0) begin
              underflow <= 1'b1;
            end else begin
              stk_con <= CON_POP;
              busy    <= 1'b1;
              state   <= POP;
            end
          end
        end

        PUSH: begin
          depth   <= depth + DEPTH_ONE;
          pc_load <= 1'b1;
          state   <= LOAD;
        end

        POP: begin
          // The stack presents the popped word on y from this edge onward.
          depth <= depth - DEPTH_ONE;
          state <= RWAIT;
        end

        RWAIT: begin
          pc_next <= stk_q;
          pc_load <= 1'b1;
          state   <= LOAD;
        end

        LOAD: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: directed table, hand sequences and randomized requests
// checked against a transaction-level model (a queue of return addresses).
module tb_call_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       call, ret, clr_err;
  logic [7:0] pc, target, stk_q;
  logic [1:0] stk_con;
  logic [7:0] stk_data, pc_next;
  logic       pc_load, busy;
  logic [3:0] depth;
  logic       overflow, underflow, illegal;

  int checks = 0;
  int errors = 0;

  call_stack_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .call(call), .ret(ret), .clr_err(clr_err),
    .pc(pc), .target(target), .stk_q(stk_q), .stk_con(stk_con),
    .stk_data(stk_data), .pc_load(pc_load), .pc_next(pc_next), .busy(busy),
    .depth(depth), .overflow(overflow), .underflow(underflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Environment stand-in for the stek LIFO (push/pop on posedge, y = popped).
  logic [7:0] stk_mem [8];
  int         stk_sp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_sp <= 0;
      stk_q  <= 8'h00;
    end else if (stk_con == 2'b01 && stk_sp < 8) begin
      stk_mem[stk_sp] <= stk_data;
      stk_sp          <= stk_sp + 1;
    end else if (stk_con == 2'b10 && stk_sp > 0) begin
      stk_q  <= stk_mem[stk_sp-1];
      stk_sp <= stk_sp - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: return-address queue and sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf, m_ill;
  logic [7:0] m_data;
  logic [1:0] x_con;
  int         x_lat;
  logic [7:0] x_pcn;

  task automatic model_step(input bit c, input bit r, input bit clr,
                            input logic [7:0] p, input logic [7:0] t);
    bit so, su, si;
    so = 0; su = 0; si = 0;
    x_con = 2'b00; x_lat = 0; x_pcn = 8'h00;
    if (c && r) si = 1;
    else if (c) begin
      if (mq.size() == 8) so = 1;
      else begin
        m_data = p + 8'd1;
        mq.push_back(m_data);
        x_con = 2'b01; x_lat = 2; x_pcn = t;
      end
    end else if (r) begin
      if (mq.size() == 0) su = 1;
      else begin
        x_pcn = mq.pop_back();
        x_con = 2'b10; x_lat = 3;
      end
    end
    m_ovf = (m_ovf && !clr) || so;
    m_unf = (m_unf && !clr) || su;
    m_ill = (m_ill && !clr) || si;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_ill = 0; m_data = 8'h00;
  endtask

  // Observed results of one request window (four cycles after it is driven).
  logic [1:0] o_con;
  int         o_ncon, o_lat, o_nload;
  logic [7:0] o_pcn;

  task automatic apply(input bit c, input bit r, input bit clr,
                       input logic [7:0] p, input logic [7:0] t);
    call = c; ret = r; clr_err = clr; pc = p; target = t;
    o_con = 2'b00; o_ncon = 0; o_lat = 0; o_nload = 0; o_pcn = 8'h00;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        call = 0; ret = 0; clr_err = 0;
        o_con = stk_con;
      end
      if (stk_con != 2'b00) o_ncon++;
      if (pc_load) begin
        if (o_nload == 0) begin
          o_lat = cyc;
          o_pcn = pc_next;
        end
        o_nload++;
      end
    end
  endtask

  task automatic mreq(input bit c, input bit r, input bit clr,
                      input logic [7:0] p, input logic [7:0] t);
    model_step(c, r, clr, p, t);
    apply(c, r, clr, p, t);
    check("stk_con", 32'(o_con), 32'(x_con));
    check("con_cycles", o_ncon, (x_con != 2'b00) ? 1 : 0);
    check("load_latency", o_lat, x_lat);
    check("load_count", o_nload, (x_lat != 0) ? 1 : 0);
    if (x_lat != 0) check("pc_next", 32'(o_pcn), 32'(x_pcn));
    check("depth", 32'(depth), mq.size());
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("busy_after", 32'(busy), 0);
    check("stk_data", 32'(stk_data), 32'(m_data));
  endtask

  typedef struct {
    bit         c, r, clr;
    logic [7:0] p, t;
    logic [1:0] e_con;
    int         e_lat;
    logic [7:0] e_pcn, e_data;
    logic [3:0] e_depth;
    bit         e_ovf, e_unf, e_ill;
  } vec_t;

  vec_t vecs [7];

  initial begin
    //           c  r  clr  pc     target  con    lat pc_next data   dep ovf unf ill
    vecs[0] = '{1, 0, 0, 8'h10, 8'h40, 2'b01, 2, 8'h40, 8'h11, 4'd1, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 8'h00, 8'h00, 2'b10, 3, 8'h11, 8'h11, 4'd0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h11, 4'd0, 0, 1, 0};
    vecs[3] = '{0, 0, 1, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h11, 4'd0, 0, 0, 0};
    vecs[4] = '{1, 1, 0, 8'h33, 8'h55, 2'b00, 0, 8'h00, 8'h11, 4'd0, 0, 0, 1};
    vecs[5] = '{1, 0, 1, 8'hFF, 8'h20, 2'b01, 2, 8'h20, 8'h00, 4'd1, 0, 0, 0};
    vecs[6] = '{0, 1, 0, 8'h00, 8'h00, 2'b10, 3, 8'h00, 8'h00, 4'd0, 0, 0, 0};

    reset = 1; call = 0; ret = 0; clr_err = 0; pc = 0; target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stk_con", 32'(stk_con), 0);
    check("rst_stk_data", 32'(stk_data), 0);
    check("rst_pc_load", 32'(pc_load), 0);
    check("rst_pc_next", 32'(pc_next), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_depth", 32'(depth), 0);
    check("rst_flags", {overflow, underflow, illegal}, 0);
    reset = 0;

    // Directed table from reset.
    for (int i = 0; i < 7; i++) begin
      model_step(vecs[i].c, vecs[i].r, vecs[i].clr, vecs[i].p, vecs[i].t);
      apply(vecs[i].c, vecs[i].r, vecs[i].clr, vecs[i].p, vecs[i].t);
      check($sformatf("t%0d_con", i), 32'(o_con), 32'(vecs[i].e_con));
      check($sformatf("t%0d_lat", i), o_lat, vecs[i].e_lat);
      if (vecs[i].e_lat != 0) check($sformatf("t%0d_pcn", i), 32'(o_pcn), 32'(vecs[i].e_pcn));
      check($sformatf("t%0d_data", i), 32'(stk_data), 32'(vecs[i].e_data));
      check($sformatf("t%0d_depth", i), 32'(depth), 32'(vecs[i].e_depth));
      check($sformatf("t%0d_flags", i), {overflow, underflow, illegal},
            {vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_ill});
    end

    // Nested calls to full depth, one overflowing call, then unwind LIFO.
    for (int i = 0; i < 8; i++) mreq(1, 0, 0, 8'(i), 8'(8'h80 + i));
    mreq(1, 0, 0, 8'h08, 8'h90);
    check("nest_overflow", 32'(overflow), 1);
    check("nest_ovf_noload", o_nload, 0);
    for (int k = 0; k < 8; k++) begin
      mreq(0, 1, 0, 8'h00, 8'h00);
      check("nest_ret_pc", 32'(o_pcn), 32'(8 - k));
    end
    mreq(0, 0, 1, 8'h00, 8'h00);

    // Reset asserted during RWAIT abandons the return.
    mreq(1, 0, 0, 8'h21, 8'h60);
    ret = 1;
    @(posedge clk); #1;
    ret = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    check("rwait_rst_con", 32'(stk_con), 0);
    check("rwait_rst_busy", 32'(busy), 0);
    check("rwait_rst_depth", 32'(depth), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    begin
      int loads = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (pc_load) loads++;
      end
      check("rwait_rst_noload", loads, 0);
      check("rwait_rst_pcnext", 32'(pc_next), 0);
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      int  sel;
      bit  c, r;
      sel = $urandom_range(0, 99);
      c = (sel < 55) || (sel >= 95);
      r = (sel >= 55 && sel < 90) || (sel >= 95);
      mreq(c, r, ($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
